// File: rtl/serial_pkg.sv
// Shared types for the serial word link.
// Receiver FSM states and bit-order selectors.
package serial_pkg;

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

  localparam int DIR_LSB_FIRST = 1;
  localparam int DIR_MSB_FIRST = 0;

endpackage

// File: rtl/shift_in_reg.sv
// Serial-in shift register; undoes the transmitter's rotate.
// nxt_o exposes the value after the current insert for same-cycle capture.
module shift_in_reg
  import serial_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIR = DIR_LSB_FIRST
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         sin_i,
  output logic [N-1:0] sr_o,
  output logic [N-1:0] nxt_o
);

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;
  logic [N-1:0] base;

  // A clear with an insert starts a fresh word from this bit
  always_comb begin
    base = clr_i ? '0 : sr_q;
    if (DIR == DIR_LSB_FIRST) begin
      nxt_o = {sin_i, base[N-1:1]};
    end else begin
      nxt_o = {base[N-2:0], sin_i};
    end
    sr_d = sr_q;
    if (en_i) begin
      sr_d = nxt_o;
    end else if (clr_i) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_o = sr_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver: reassembles N-bit words from a bit strobe
// and offers them on a valid/ready holding register.
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIR = DIR_LSB_FIRST
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         SIN,
  input  logic         SVALID,
  input  logic         START,
  input  logic         CLR_OVR,
  output logic [N-1:0] Y,
  output logic         YVALID,
  input  logic         YREADY,
  output logic         BUSY,
  output logic         OVERRUN
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  y_q, y_d;
  logic          yv_q, yv_d;
  logic          ovr_q, ovr_d;

  logic          sr_en;
  logic          sr_clr;
  logic          done;
  logic [N-1:0]  sr;
  logic [N-1:0]  nxt;

  shift_in_reg #(
    .N   (N),
    .DIR (DIR)
  ) u_sr (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .en_i    (sr_en),
    .clr_i   (sr_clr),
    .sin_i   (SIN),
    .sr_o    (sr),
    .nxt_o   (nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_en   = 1'b0;
    sr_clr  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (SVALID && START) begin
          sr_en   = 1'b1;
          sr_clr  = 1'b1;
          cnt_d   = CW'(1);
          state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (SVALID) begin
          sr_en = 1'b1;
          if (START) begin
            sr_clr = 1'b1;
            cnt_d  = CW'(1);
          end else if (cnt_q == LAST) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = RX_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  // A held word may only be replaced when it is consumed the same edge
  always_comb begin
    y_d   = y_q;
    yv_d  = yv_q;
    ovr_d = ovr_q;
    if (done && (!yv_q || YREADY)) begin
      y_d  = nxt;
      yv_d = 1'b1;
    end else if (yv_q && YREADY) begin
      yv_d = 1'b0;
    end
    if (done && yv_q && !YREADY) begin
      ovr_d = 1'b1;
    end else if (CLR_OVR) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Y       = y_q;
  assign YVALID  = yv_q;
  assign BUSY    = (state_q == RX_SHIFT);
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: an LSB-first and an MSB-first
// instance receive the same words; a scoreboard checks deliveries.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       SVALID = 1'b0;
  logic       START = 1'b0;
  logic       CLR_OVR = 1'b0;
  logic       YREADY = 1'b0;
  logic       sin [2];
  logic [7:0] y [2];
  logic       yv [2];
  logic       busy [2];
  logic       ovr [2];

  int         compared = 0;
  int         mism = 0;
  bit         mon_en = 0;
  bit         exp_ovr = 0;
  bit         in_frame = 0;
  int         rdy_mode = 1;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  serial_word_receiver #(.N(8), .DIR(1)) u_lsb (
    .CLK     (clk),
    .RST_N   (RST_N),
    .SIN     (sin[1]),
    .SVALID  (SVALID),
    .START   (START),
    .CLR_OVR (CLR_OVR),
    .Y       (y[1]),
    .YVALID  (yv[1]),
    .YREADY  (YREADY),
    .BUSY    (busy[1]),
    .OVERRUN (ovr[1])
  );

  serial_word_receiver #(.N(8), .DIR(0)) u_msb (
    .CLK     (clk),
    .RST_N   (RST_N),
    .SIN     (sin[0]),
    .SVALID  (SVALID),
    .START   (START),
    .CLR_OVR (CLR_OVR),
    .Y       (y[0]),
    .YVALID  (yv[0]),
    .YREADY  (YREADY),
    .BUSY    (busy[0]),
    .OVERRUN (ovr[0])
  );

  function automatic void chk(string nm, int d, logic [7:0] got,
                              logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mism++;
      $display("FAIL %s dut%0d got %h want %h", nm, d, got, exp);
    end
  endfunction

  // Monitor: YVALID must track "scoreboard non-empty"; Y checked on handshake
  always @(negedge clk) begin
    if (mon_en) begin
      bit pop;
      pop = 0;
      for (int d = 0; d < 2; d++) begin
        chk("yvalid", d, {7'd0, yv[d]}, {7'd0, sb.size() != 0});
        chk("overrun", d, {7'd0, ovr[d]}, {7'd0, exp_ovr});
        if (yv[d] && YREADY && sb.size() != 0) begin
          chk("y", d, y[d], sb[0]);
          pop = 1;
        end
      end
      if (pop) void'(sb.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) YREADY = 1'($urandom % 2);
    end
  end

  task automatic set_rdy(input int m);
    rdy_mode = m;
    if (m < 2) YREADY = m[0];
  endtask

  task automatic gap(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      SVALID = stray ? 1'($urandom % 2) : 1'b0;
      START = 1'b0;
      sin[1] = 1'($urandom);
      sin[0] = 1'($urandom);
      @(posedge clk);
      #1;
      if (stray) begin
        for (int d = 0; d < 2; d++) chk("busy_idle", d, {7'd0, busy[d]}, 8'd0);
      end
    end
    SVALID = 1'b0;
  endtask

  // Send bits 0..nbits-1 of word w; a full frame is 8 bits
  task automatic send(input logic [7:0] w, input int nbits,
                      input int maxgap, input bit clr_last);
    for (int k = 0; k < nbits; k++) begin
      bit last;
      last = (k == 7);
      if (maxgap > 0) gap($urandom_range(0, maxgap), k == 0 && !in_frame);
      SVALID = 1'b1;
      START = (k == 0);
      sin[1] = w[k];
      sin[0] = w[7-k];
      if (last) begin
        CLR_OVR = clr_last;
        @(negedge clk);
        #1;
        if (sb.size() == 0) begin
          sb.push_back(w);
          if (clr_last) exp_ovr = 0;
        end else begin
          exp_ovr = 1;
        end
      end
      @(posedge clk);
      #1;
      SVALID = 1'b0;
      START = 1'b0;
      CLR_OVR = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, {7'd0, busy[d]}, {7'd0, !last});
        if (last) chk("yvalid_lat", d, {7'd0, yv[d]}, 8'd1);
      end
    end
    in_frame = (nbits < 8);
  endtask

  task automatic clear_ovr();
    CLR_OVR = 1'b1;
    @(posedge clk);
    #1;
    CLR_OVR = 1'b0;
    exp_ovr = 0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    RST_N = 1'b0;
    SVALID = 1'b1;
    START = 1'b0;
    CLR_OVR = 1'b0;
    sin[1] = 1'b1;
    sin[0] = 1'b1;
    @(posedge clk);
    #1;
    SVALID = 1'b0;
    sb.delete();
    exp_ovr = 0;
    in_frame = 0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_y", d, y[d], 8'h00);
      chk("rst_yvalid", d, {7'd0, yv[d]}, 8'd0);
      chk("rst_busy", d, {7'd0, busy[d]}, 8'd0);
      chk("rst_overrun", d, {7'd0, ovr[d]}, 8'd0);
    end
    RST_N = 1'b1;
    mon_en = 1;
  endtask

  initial begin
    sin[0] = 1'b0;
    sin[1] = 1'b0;
    set_rdy(1);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic LSB/MSB-first frame, back-to-back strobes
    send(8'hA5, 8, 0, 0);
    gap(2, 1);

    // Random strobe gaps inside the frame
    send(8'h3C, 8, 3, 0);
    gap(2, 1);

    // Consumer stalled: second word dropped, first word held
    set_rdy(0);
    send(8'h11, 8, 1, 0);
    send(8'h22, 8, 1, 0);
    gap(1, 0);
    for (int d = 0; d < 2; d++) chk("held_y", d, y[d], 8'h11);
    clear_ovr();
    gap(1, 0);
    set_rdy(1);
    gap(2, 0);

    // Overrun set coinciding with a clear: set wins
    set_rdy(0);
    send(8'h33, 8, 0, 0);
    send(8'h44, 8, 0, 1);
    gap(1, 0);
    clear_ovr();
    set_rdy(1);
    gap(2, 0);

    // Back-to-back frames with the consumer ready
    send(8'hF0, 8, 0, 0);
    send(8'h0F, 8, 0, 0);
    gap(2, 0);

    // Resync: START mid-frame abandons the partial word
    send(8'hFF, 4, 0, 0);
    send(8'h81, 8, 0, 0);
    gap(2, 0);

    // Reset mid-frame while a word is held
    set_rdy(0);
    send(8'h77, 8, 0, 0);
    send(8'hC3, 5, 0, 0);
    do_reset();
    set_rdy(1);
    send(8'h5A, 8, 1, 0);
    gap(2, 0);

    // Randomised traffic with a random consumer
    set_rdy(2);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) send(8'($urandom), $urandom_range(1, 7), 2, 0);
      send(8'($urandom), 8, 3, ($urandom_range(0, 5) == 0));
    end

    set_rdy(1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    compared++;
    if (sb.size() != 0) begin
      mism++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    gap(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
